// File: rtl/vga_timing.sv
// rtl/vga_timing.sv - VGA sync/blank generator presenting pixel FIFO data on the RGB bus
// pixel_clk, pixel_rst_n : pixel clock, asynchronous active-low reset
// fifo_rdata, fifo_rempty : show-ahead FIFO head word and empty flag
// fifo_wfull              : FIFO full, already in the pixel_clk domain
// fifo_read               : pop the FIFO head this cycle
// VGA_CLK                 : inverted pixel clock for the DAC
// VGA_HS, VGA_VS          : horizontal/vertical sync, active low
// VGA_BLANK               : 1 = active pixel, 0 = blanked
// VGA_RGB                 : pixel data, 0 when blanked or starved
// underflow               : sticky, FIFO was empty on a pixel that should have been read
module vga_timing #(
    parameter int HDISP  = 800,
    parameter int VDISP  = 480,
    parameter int HFP    = 40,
    parameter int HPULSE = 48,
    parameter int HBP    = 40,
    parameter int VFP    = 13,
    parameter int VPULSE = 3,
    parameter int VBP    = 29
) (
    input  logic        pixel_clk,
    input  logic        pixel_rst_n,
    input  logic [23:0] fifo_rdata,
    input  logic        fifo_rempty,
    input  logic        fifo_wfull,
    output logic        fifo_read,
    output logic        VGA_CLK,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        VGA_BLANK,
    output logic [23:0] VGA_RGB,
    output logic        underflow
);

    localparam int HT = HFP + HPULSE + HBP + HDISP;
    localparam int VT = VFP + VPULSE + VBP + VDISP;
    localparam int HW = $clog2(HT);
    localparam int VW = $clog2(VT);

    localparam logic [HW-1:0] H_LAST  = HW'(HT - 1);
    localparam logic [HW-1:0] H_SYNC0 = HW'(HFP);
    localparam logic [HW-1:0] H_SYNC1 = HW'(HFP + HPULSE);
    localparam logic [HW-1:0] H_ACT0  = HW'(HFP + HPULSE + HBP);
    localparam logic [VW-1:0] V_LAST  = VW'(VT - 1);
    localparam logic [VW-1:0] V_SYNC0 = VW'(VFP);
    localparam logic [VW-1:0] V_SYNC1 = VW'(VFP + VPULSE);
    localparam logic [VW-1:0] V_ACT0  = VW'(VFP + VPULSE + VBP);

    typedef enum logic {WAIT_FILL, RUN} state_t;

    state_t        state;
    state_t        state_next;
    logic [HW-1:0] hcnt;
    logic [VW-1:0] vcnt;
    logic          seen;
    logic          h_last;
    logic          v_last;
    logic          hsync;
    logic          vsync;
    logic          active;
    logic          frame_start;
    logic          starved;

    assign VGA_CLK     = ~pixel_clk;
    assign h_last      = (hcnt == H_LAST);
    assign v_last      = (vcnt == V_LAST);
    assign hsync       = (hcnt >= H_SYNC0) && (hcnt < H_SYNC1);
    assign vsync       = (vcnt >= V_SYNC0) && (vcnt < V_SYNC1);
    assign active      = (hcnt >= H_ACT0) && (vcnt >= V_ACT0);
    assign frame_start = (hcnt == '0) && (vcnt == '0);
    assign starved     = (state == RUN) && active && fifo_rempty;

    // Raster counters free-run in both states so syncs are present while filling.
    always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
        if (!pixel_rst_n) begin
            hcnt <= '0;
            vcnt <= '0;
        end else begin
            if (h_last) begin
                hcnt <= '0;
                vcnt <= v_last ? '0 : vcnt + 1'b1;
            end else begin
                hcnt <= hcnt + 1'b1;
            end
        end
    end

    // Output starts only at a frame boundary once the FIFO has been seen full,
    // so the first displayed pixel is the first word of a frame.
    always_comb begin
        state_next = state;
        fifo_read  = 1'b0;
        case (state)
            WAIT_FILL: begin
                if (frame_start && (seen || fifo_wfull)) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                fifo_read = active && !fifo_rempty;
            end
            default: state_next = WAIT_FILL;
        endcase
    end

    always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
        if (!pixel_rst_n) begin
            state <= WAIT_FILL;
            seen  <= 1'b0;
        end else begin
            state <= state_next;
            if (state == WAIT_FILL && fifo_wfull) begin
                seen <= 1'b1;
            end
        end
    end

    // Video outputs lag the counters by one cycle; the word popped this cycle
    // is shown on the next edge together with BLANK=1.
    always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
        if (!pixel_rst_n) begin
            VGA_HS    <= 1'b1;
            VGA_VS    <= 1'b1;
            VGA_BLANK <= 1'b0;
            VGA_RGB   <= '0;
            underflow <= 1'b0;
        end else begin
            VGA_HS    <= ~hsync;
            VGA_VS    <= ~vsync;
            VGA_BLANK <= (state == RUN) && active;
            VGA_RGB   <= fifo_read ? fifo_rdata : 24'd0;
            if (starved) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vga_timing.sv
// tb/tb_vga_timing.sv - self-checking bench for vga_timing against a raster-position reference model
module tb_vga_timing;

    localparam int HDISP  = 20;
    localparam int VDISP  = 8;
    localparam int HFP    = 5;
    localparam int HPULSE = 4;
    localparam int HBP    = 3;
    localparam int VFP    = 2;
    localparam int VPULSE = 2;
    localparam int VBP    = 3;
    localparam int HT     = HFP + HPULSE + HBP + HDISP;
    localparam int VT     = VFP + VPULSE + VBP + VDISP;
    localparam int FRAME  = HT * VT;
    localparam int HACT   = HFP + HPULSE + HBP;
    localparam int VACT   = VFP + VPULSE + VBP;

    logic        pixel_clk = 1'b0;
    logic        pixel_rst_n = 1'b0;
    logic [23:0] fifo_rdata = 24'd0;
    logic        fifo_rempty = 1'b1;
    logic        fifo_wfull = 1'b0;
    logic        fifo_read;
    logic        VGA_CLK;
    logic        VGA_HS;
    logic        VGA_VS;
    logic        VGA_BLANK;
    logic [23:0] VGA_RGB;
    logic        underflow;

    vga_timing #(
        .HDISP(HDISP), .VDISP(VDISP), .HFP(HFP), .HPULSE(HPULSE), .HBP(HBP),
        .VFP(VFP), .VPULSE(VPULSE), .VBP(VBP)
    ) dut (
        .pixel_clk  (pixel_clk),
        .pixel_rst_n(pixel_rst_n),
        .fifo_rdata (fifo_rdata),
        .fifo_rempty(fifo_rempty),
        .fifo_wfull (fifo_wfull),
        .fifo_read  (fifo_read),
        .VGA_CLK    (VGA_CLK),
        .VGA_HS     (VGA_HS),
        .VGA_VS     (VGA_VS),
        .VGA_BLANK  (VGA_BLANK),
        .VGA_RGB    (VGA_RGB),
        .underflow  (underflow)
    );

    always #5 pixel_clk = ~pixel_clk;

    int vectors = 0;
    int miscompares = 0;

    // reference model state: k = clock edges since reset release
    int          k;
    bit          m_run;
    bit          m_seen;
    bit          m_uf;
    logic [23:0] head;
    int          empty_pct;
    int          force_empty;
    int          pops;
    int          first_pop_k;
    int          hs_low;
    int          vs_low;
    int          blank_hi;
    bit          prev_vs;
    int          last_fall;
    bit          period_on;

    function automatic bit in_hsync(int t);
        int h;
        h = t % HT;
        return (h >= HFP) && (h < HFP + HPULSE);
    endfunction

    function automatic bit in_vsync(int t);
        int v;
        v = (t / HT) % VT;
        return (v >= VFP) && (v < VFP + VPULSE);
    endfunction

    function automatic bit in_active(int t);
        return ((t % HT) >= HACT) && (((t / HT) % VT) >= VACT);
    endfunction

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b at cycle %0d", tag, obs, exp, k);
        end
    endtask

    task automatic chk24(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp, k);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d at cycle %0d", tag, obs, exp, k);
        end
    endtask

    // One pixel clock: drive inputs after the falling edge, check the
    // combinational pop, then check the registered outputs after the next edge.
    task automatic tick();
        bit          act;
        bit          pop;
        bit          e_hs;
        bit          e_vs;
        bit          e_blank;
        logic [23:0] e_rgb;
        act = in_active(k);
        if (force_empty > 0 && act && m_run) begin
            fifo_rempty = 1'b1;
            force_empty--;
        end else begin
            fifo_rempty = ($urandom_range(99) < empty_pct);
        end
        fifo_rdata = fifo_rempty ? 24'($urandom) : head;
        #1;
        chk1("fifo_read", fifo_read, m_run && act && !fifo_rempty);
        chk1("vga_clk", VGA_CLK, ~pixel_clk);
        pop = fifo_read;
        if (pop) begin
            pops++;
            if (first_pop_k < 0) first_pop_k = k;
        end
        e_hs    = !in_hsync(k);
        e_vs    = !in_vsync(k);
        e_blank = m_run && act;
        e_rgb   = (m_run && act && !fifo_rempty) ? head : 24'd0;
        if (m_run && act && fifo_rempty) m_uf = 1'b1;
        if (!m_run) begin
            if ((k % FRAME) == 0 && (m_seen || fifo_wfull)) m_run = 1'b1;
            if (fifo_wfull) m_seen = 1'b1;
        end
        @(posedge pixel_clk);
        if (pop) head = head + 24'd1;
        @(negedge pixel_clk);
        k++;
        chk1("hs", VGA_HS, e_hs);
        chk1("vs", VGA_VS, e_vs);
        chk1("blank", VGA_BLANK, e_blank);
        chk24("rgb", VGA_RGB, e_rgb);
        chk1("underflow", underflow, m_uf);
        if (!VGA_HS) hs_low++;
        if (!VGA_VS) vs_low++;
        if (VGA_BLANK) blank_hi++;
        if (period_on && prev_vs && !VGA_VS) begin
            if (last_fall >= 0) chki("vs_period", k - last_fall, FRAME);
            last_fall = k;
        end
        prev_vs = VGA_VS;
    endtask

    // Asynchronous reset taken in the middle of a clock phase, released on a falling edge.
    task automatic do_reset();
        #($urandom_range(1, 3));
        pixel_rst_n = 1'b0;
        #1;
        chk1("rst_hs", VGA_HS, 1'b1);
        chk1("rst_vs", VGA_VS, 1'b1);
        chk1("rst_blank", VGA_BLANK, 1'b0);
        chk24("rst_rgb", VGA_RGB, 24'd0);
        chk1("rst_underflow", underflow, 1'b0);
        chk1("rst_fifo_read", fifo_read, 1'b0);
        @(negedge pixel_clk);
        @(negedge pixel_clk);
        pixel_rst_n = 1'b1;
        k = 0;
        m_run = 1'b0;
        m_seen = 1'b0;
        m_uf = 1'b0;
        prev_vs = 1'b1;
        last_fall = -1;
    endtask

    task automatic clear_stats();
        pops = 0;
        hs_low = 0;
        vs_low = 0;
        blank_hi = 0;
        first_pop_k = -1;
    endtask

    initial begin
        empty_pct = 0;
        force_empty = 0;
        head = 24'd0;
        period_on = 1'b0;
        clear_stats();
        @(negedge pixel_clk);
        do_reset();

        // Fill wait: no full observation, then a single mid-frame full pulse.
        repeat (FRAME + $urandom_range(1, FRAME - 2)) tick();
        chki("no_pop_before_fill", pops, 0);
        fifo_wfull = 1'b1;
        tick();
        fifo_wfull = 1'b0;
        for (int i = 0; i < FRAME && (k % FRAME) != 0; i++) tick();
        chki("frame_aligned", k % FRAME, 0);
        chki("no_pop_until_frame", pops, 0);

        // First running frame: geometry and data path.
        clear_stats();
        head = 24'd0;
        repeat (FRAME) tick();
        chki("first_pop_h", first_pop_k % HT, HACT);
        chki("first_pop_v", (first_pop_k / HT) % VT, VACT);
        chki("pops_per_frame", pops, HDISP * VDISP);
        chki("last_rgb_value", int'(head), HDISP * VDISP);
        chki("hs_low_cycles", hs_low, HPULSE * VT);
        chki("vs_low_cycles", vs_low, VPULSE * HT);
        chki("blank_high_cycles", blank_hi, HDISP * VDISP);

        // Underflow: five starved active pixels, then random starvation.
        clear_stats();
        force_empty = 5;
        for (int i = 0; i < FRAME && force_empty > 0; i++) tick();
        chki("forced_empties_done", force_empty, 0);
        tick();
        chk1("underflow_set", underflow, 1'b1);
        empty_pct = 25;
        repeat (FRAME) tick();
        chk1("underflow_sticky", underflow, 1'b1);
        empty_pct = 0;

        // Reset mid-line clears everything; then run with the FIFO always full.
        repeat ($urandom_range(3, HT - 3)) tick();
        do_reset();
        fifo_wfull = 1'b1;
        clear_stats();
        head = 24'd0;
        period_on = 1'b1;
        repeat (3 * FRAME + 2) tick();
        chki("pops_3_frames", pops, 3 * HDISP * VDISP);
        chk1("no_underflow", underflow, 1'b0);
        chki("vs_falls_seen", (last_fall >= 0) ? 1 : 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/vga_timing.md
# vga_timing

Pixel-clock-domain display stage that drives the video output port of the video controller. It generates VGA horizontal/vertical sync and blanking from programmable porch/pulse parameters, pops pixels from the upstream dual-clock pixel FIFO during active display, and presents them on the RGB bus. It sits between the pixel FIFO (written by the framebuffer reader) and the screen/DAC, and is instantiated in `Top` with `HDISP`/`VDISP` overridden for simulation.

## Interface
Parameters:
- `HDISP`, 800: active pixels per line
- `VDISP`, 480: active lines per frame
- `HFP`, 40: horizontal front porch (pixels)
- `HPULSE`, 48: horizontal sync pulse (pixels)
- `HBP`, 40: horizontal back porch (pixels)
- `VFP`, 13: vertical front porch (lines)
- `VPULSE`, 3: vertical sync pulse (lines)
- `VBP`, 29: vertical back porch (lines)

Ports (one clock; reset is asynchronous and active-low):
- `pixel_clk`  in  1  pixel clock
- `pixel_rst_n`  in  1  asynchronous active-low reset
- `fifo_rdata`  in  24  FIFO head word, show-ahead, valid when `fifo_rempty`=0
- `fifo_rempty`  in  1  FIFO empty
- `fifo_wfull`  in  1  FIFO full, already synchronised to `pixel_clk`
- `fifo_read`  out  1  pop FIFO head this cycle
- `VGA_CLK`  out  1  `~pixel_clk`
- `VGA_HS`  out  1  horizontal sync, active low
- `VGA_VS`  out  1  vertical sync, active low
- `VGA_BLANK`  out  1  1 = active pixel, 0 = blanked
- `VGA_RGB`  out  24  pixel data, 0 when blanked
- `underflow`  out  1  sticky: FIFO empty during a pixel that should have been read

## Operation
- Counters: `hcnt` 0..HT-1 with HT = HFP+HPULSE+HBP+HDISP; `vcnt` 0..VT-1 with VT = VFP+VPULSE+VBP+VDISP; widths = `$clog2` of HT/VT. `vcnt` increments when `hcnt` wraps HT-1→0; `vcnt` wraps VT-1→0 on the same cycle as `hcnt` wraps.
- Line layout: front porch [0,HFP), sync [HFP,HFP+HPULSE), back porch, active [HFP+HPULSE+HBP, HT). Frame layout identical with V parameters.
- hsync = `hcnt` in sync region; vsync = `vcnt` in sync region (line-granular, no per-pixel offset); active = both counters in active regions.
- FSM, 2 states:
  - WAIT_FILL (reset state): counters and syncs run, `VGA_BLANK`=0, `fifo_read`=0. Latch `fifo_wfull` seen=1 when observed high. Go to RUN on the cycle where `hcnt`=0 and `vcnt`=0 and seen=1 (or `fifo_wfull`=1 that cycle).
  - RUN: `fifo_read` = active && !`fifo_rempty` (combinational from counters and FIFO flag). Stays in RUN until reset.
- Underflow: in RUN, active && `fifo_rempty` → pixel output 0, no pop, `underflow`←1 (sticky). No re-synchronisation; the frame continues.
- Never pops outside active display; never pops in WAIT_FILL.

## Timing
- `VGA_HS`, `VGA_VS`, `VGA_BLANK`, `VGA_RGB`, `underflow` registered: reflect counter state of the previous cycle (1-cycle latency). `fifo_read` is same-cycle with its counter value, so the popped word appears on `VGA_RGB` on the next edge, aligned with `VGA_BLANK`=1.
- `VGA_RGB` ← `fifo_rdata` when RUN && active && !`fifo_rempty`, else 0.
- Reset (async assert, deassert synchronous to `pixel_clk`): `hcnt`=`vcnt`=0, state WAIT_FILL, seen=0, `VGA_HS`=1, `VGA_VS`=1, `VGA_BLANK`=0, `VGA_RGB`=0, `underflow`=0, `fifo_read`=0 (RUN=0). Reset mid-frame aborts immediately; next frame requires a new full-FIFO observation.
- Default period: line 928 cycles, frame 928×525 = 487200 cycles.

## Test plan
- Reset: hold `pixel_rst_n`=0 mid-line → outputs at reset values within same cycle, no clock needed; after release first `VGA_HS` low at cycle HFP+1 (cycle 41 defaults).
- Sync geometry (HDISP=160, VDISP=90, defaults else): HS low exactly 48 cycles every 288; VS low exactly 3×288 = 864 cycles every 288×135 = 38880; BLANK high 160 cycles per line on 90 lines.
- Fill wait: `fifo_wfull` pulsed mid-frame 0 → zero `fifo_read` until next frame start, then first pop at `hcnt`=128, `vcnt`=45.
- Data path: FIFO model returns incrementing 24-bit values → `VGA_RGB` sequence 0,1,2,… aligned with `VGA_BLANK`=1, exactly HDISP×VDISP pops per frame, `VGA_RGB`=0 whenever blanked.
- Underflow: force `fifo_rempty`=1 for 5 active pixels → 5 zero pixels, no pops those cycles, `underflow` rises 1 cycle after the first and stays 1 until reset.
- Continuous FIFO never empty over 3 frames → `underflow`=0, frame period 38880 cycles (sim params) with no drift.
